// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with wrap-bit pointers, level flags and
// registered overflow/underflow pulses. FWFT selects registered or fall-through read data.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = $clog2(DEPTH),
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wt_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  generate
    if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
      $error("sync_fifo_param: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
    end
    if (PTR_WIDTH != $clog2(DEPTH)) begin : g_bad_ptr
      $error("sync_fifo_param: PTR_WIDTH must equal clog2(DEPTH)");
    end
  endgenerate

  localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0] AF_CNT  = (PTR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AE_CNT  = (PTR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wr_ptr;
  logic [PTR_WIDTH:0]    rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_addr;
  logic [PTR_WIDTH-1:0]  rd_addr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_addr = wr_ptr[PTR_WIDTH-1:0];
  assign rd_addr = rd_ptr[PTR_WIDTH-1:0];

  // Flags come from the pre-edge pointers, so same-cycle ops never unblock each other.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) && (wr_addr == rd_addr);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  assign wr_acc = wt_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wt_en & full  & ~flush;
      underflow <= rd_en & empty & ~flush;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage is never reset; a reset cycle simply blocks the write.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_addr] <= wdata;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (rst)         rdata_q <= '0;
        else if (rd_acc) rdata_q <= mem[rd_addr];
      end
      assign rdata = rdata_q;
    end else begin : g_fwft_read
      assign rdata = empty ? '0 : mem[rd_addr];
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a registered-read instance and a
// fall-through instance, each checked against hand-computed values.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst, wt_en, rd_en, flush;
  logic [7:0] wdata, rdata;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_rst, f_wt_en, f_rd_en, f_flush;
  logic [7:0] f_wdata, f_rdata;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .wt_en(wt_en), .wdata(wdata), .rd_en(rd_en), .flush(flush),
    .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst(f_rst), .wt_en(f_wt_en), .wdata(f_wdata), .rd_en(f_rd_en), .flush(f_flush),
    .rdata(f_rdata), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check_val("rst_count", 32'(count), 0);
    check_val("rst_empty", 32'(empty), 1);
    check_val("rst_full", 32'(full), 0);
    check_val("rst_ae", 32'(almost_empty), 1);
    check_val("rst_af", 32'(almost_full), 0);
    check_val("rst_ovf", 32'(overflow), 0);
    check_val("rst_unf", 32'(underflow), 0);
    check_val("rst_rdata", 32'(rdata), 0);
  endtask

  task automatic check_fwft_reset_state();
    check_val("f_rst_count", 32'(f_count), 0);
    check_val("f_rst_empty", 32'(f_empty), 1);
    check_val("f_rst_full", 32'(f_full), 0);
    check_val("f_rst_ae", 32'(f_almost_empty), 1);
    check_val("f_rst_af", 32'(f_almost_full), 0);
    check_val("f_rst_ovf", 32'(f_overflow), 0);
    check_val("f_rst_unf", 32'(f_underflow), 0);
    check_val("f_rst_rdata", 32'(f_rdata), 0);
  endtask

  initial begin
    rst = 1'b1; wt_en = 1'b0; rd_en = 1'b0; flush = 1'b0; wdata = '0;
    f_rst = 1'b1; f_wt_en = 1'b0; f_rd_en = 1'b0; f_flush = 1'b0; f_wdata = '0;
    tick();
    rst = 1'b0; f_rst = 1'b0;
    check_reset_state();
    check_fwft_reset_state();

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wt_en = 1'b1; wdata = 8'(i);
      tick();
      check_val("fill_count", 32'(count), 32'(i));
      check_val("fill_af", 32'(almost_full), (i >= 14) ? 1 : 0);
      check_val("fill_ae", 32'(almost_empty), (i <= 2) ? 1 : 0);
      check_val("fill_full", 32'(full), (i == 16) ? 1 : 0);
      check_val("fill_empty", 32'(empty), 0);
    end

    // Rejected 17th write
    wdata = 8'hFF;
    tick();
    wt_en = 1'b0;
    check_val("ovf_pulse", 32'(overflow), 1);
    check_val("ovf_count", 32'(count), 16);
    tick();
    check_val("ovf_clear", 32'(overflow), 0);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      tick();
      check_val("drain_data", 32'(rdata), 32'(i));
      check_val("drain_count", 32'(count), 32'(16 - i));
    end
    rd_en = 1'b0;
    check_val("drain_empty", 32'(empty), 1);
    check_val("drain_unf", 32'(underflow), 0);

    // Reads at empty
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1;
      tick();
      check_val("unf_pulse", 32'(underflow), 1);
      check_val("unf_rdata", 32'(rdata), 32'h10);
      check_val("unf_count", 32'(count), 0);
    end
    rd_en = 1'b0;
    tick();
    check_val("unf_clear", 32'(underflow), 0);

    // Fill to 8, then 40 cycles of simultaneous read/write across wrap
    for (int i = 0; i < 8; i++) begin
      wt_en = 1'b1; wdata = 8'(8'h20 + i);
      tick();
    end
    check_val("mid_count", 32'(count), 8);
    for (int k = 0; k < 40; k++) begin
      wt_en = 1'b1; rd_en = 1'b1; wdata = 8'(8'h28 + k);
      tick();
      check_val("rw_data", 32'(rdata), 32'(8'h20 + k));
      check_val("rw_count", 32'(count), 8);
      check_val("rw_flags", {28'd0, full, empty, almost_full, almost_empty}, 0);
      check_val("rw_pulses", {30'd0, overflow, underflow}, 0);
    end
    wt_en = 1'b0;

    // Read 3 to reach count 5
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("pre_flush_data", 32'(rdata), 32'(8'h48 + i));
    end
    rd_en = 1'b0;
    check_val("pre_flush_count", 32'(count), 5);

    // Flush beats same-cycle write and read
    flush = 1'b1; wt_en = 1'b1; rd_en = 1'b1; wdata = 8'h99;
    tick();
    flush = 1'b0; wt_en = 1'b0; rd_en = 1'b0;
    check_val("flush_count", 32'(count), 0);
    check_val("flush_empty", 32'(empty), 1);
    check_val("flush_pulses", {30'd0, overflow, underflow}, 0);
    check_val("flush_rdata", 32'(rdata), 32'h4A);
    wt_en = 1'b1; wdata = 8'h5C;
    tick();
    wt_en = 1'b0;
    check_val("post_flush_count", 32'(count), 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_val("post_flush_data", 32'(rdata), 32'h5C);
    check_val("post_flush_empty", 32'(empty), 1);

    // Reset mid-operation wins over write
    for (int i = 0; i < 3; i++) begin
      wt_en = 1'b1; wdata = 8'(8'h70 + i);
      tick();
    end
    rst = 1'b1; rd_en = 1'b1;
    tick();
    rst = 1'b0; wt_en = 1'b0; rd_en = 1'b0;
    check_reset_state();

    // Fall-through instance
    f_wt_en = 1'b1; f_wdata = 8'hA5;
    tick();
    f_wt_en = 1'b0;
    check_val("fwft_first", 32'(f_rdata), 32'hA5);
    check_val("fwft_count1", 32'(f_count), 1);
    for (int i = 0; i < 6; i++) begin
      f_wt_en = 1'b1; f_wdata = 8'(8'hB0 + i);
      tick();
    end
    f_wt_en = 1'b0;
    check_val("fwft_count7", 32'(f_count), 7);
    check_val("fwft_head", 32'(f_rdata), 32'hA5);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    check_val("fwft_pop", 32'(f_rdata), 32'hB0);
    f_wt_en = 1'b1; f_wdata = 8'hB6;
    tick();
    f_wt_en = 1'b0;
    check_val("fwft_count7b", 32'(f_count), 7);
    f_rst = 1'b1; f_rd_en = 1'b1; f_wt_en = 1'b1;
    tick();
    f_rst = 1'b0; f_rd_en = 1'b0; f_wt_en = 1'b0;
    check_fwft_reset_state();

    f_wt_en = 1'b1; f_wdata = 8'hC1;
    tick();
    f_wdata = 8'hC2;
    tick();
    f_wt_en = 1'b0;
    check_val("fwft_c1", 32'(f_rdata), 32'hC1);
    f_rd_en = 1'b1;
    tick();
    check_val("fwft_c2", 32'(f_rdata), 32'hC2);
    tick();
    f_rd_en = 1'b0;
    check_val("fwft_empty", 32'(f_empty), 1);
    check_val("fwft_empty_rdata", 32'(f_rdata), 0);
    tick();
    check_val("fwft_unf", 32'(f_underflow), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
